// File: rtl/inst_window_if.sv
// Dispatch-stage window bus: fetch push side, decoder window side, issue/status.
// master = fetch + decoder side, slave = the window controller.
interface inst_window_if #(
    parameter int PTRW = 3
);
    logic            in_valid;
    logic [63:0]     in_data;
    logic            in_ready;
    logic            flush;
    logic [63:0]     win0;
    logic [63:0]     win1;
    logic [63:0]     win2;
    logic [63:0]     win3;
    logic [63:0]     win4;
    logic [2:0]      win_count;
    logic [2:0]      dec_len;
    logic            dec_ready;
    logic            issue_fire;
    logic            len_err;
    logic [PTRW:0]   occupancy;

    modport master (
        output in_valid, in_data, flush, dec_len, dec_ready,
        input  in_ready, win0, win1, win2, win3, win4, win_count,
               issue_fire, len_err, occupancy
    );

    modport slave (
        input  in_valid, in_data, flush, dec_len, dec_ready,
        output in_ready, win0, win1, win2, win3, win4, win_count,
               issue_fire, len_err, occupancy
    );
endinterface

// File: rtl/inst_window.sv
// Instruction-stream window: circular queue of 64-bit longs exposing the oldest
// five to the decoder and retiring dec_len longs per issued instruction.

// One window slot: reads mem[head+K] when at least K+1 longs are buffered.
module inst_window_slot #(
    parameter int DEPTH = 8,
    parameter int PTRW  = 3,
    parameter int K     = 0
) (
    input  logic                   en,
    input  logic [PTRW-1:0]        head,
    input  logic [PTRW:0]          occ,
    input  logic [DEPTH-1:0][63:0] mem,
    output logic [63:0]            win
);
    logic [PTRW-1:0] idx;

    // Pointer arithmetic wraps naturally at DEPTH (power of two).
    assign idx = head + PTRW'(K);
    assign win = (en && (occ > (PTRW+1)'(K))) ? mem[idx] : '0;
endmodule

module inst_window #(
    parameter int DEPTH = 8,
    parameter int PTRW  = 3
) (
    input  logic         clk,
    input  logic         rst,
    inst_window_if.slave bus
);
    localparam int WIN = 5;

    logic [DEPTH-1:0][63:0] mem;
    logic [PTRW-1:0]        head;
    logic [PTRW-1:0]        tail;
    logic [PTRW:0]          occ;
    logic                   len_err_q;
    logic                   push;
    logic                   legal;
    logic                   fire;
    logic [2:0]             win_count;
    logic [WIN-1:0][63:0]   win;

    // Readiness comes from registered occupancy only; a retire this cycle
    // does not open a slot until the next one.
    assign bus.in_ready = !rst && !bus.flush && (occ < (PTRW+1)'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;

    assign legal     = (bus.dec_len != 3'd0) && (bus.dec_len <= 3'd5);
    assign win_count = rst ? 3'd0 :
                       (occ >= (PTRW+1)'(WIN)) ? 3'd5 : occ[2:0];

    // dec_len is a function of the window, and the window depends only on
    // registered head/occ, so fire never loops back into win0..win4.
    assign fire = !rst && !bus.flush && bus.dec_ready && legal &&
                  (bus.dec_len <= win_count);

    for (genvar k = 0; k < WIN; k++) begin : g_slot
        inst_window_slot #(
            .DEPTH (DEPTH),
            .PTRW  (PTRW),
            .K     (k)
        ) u_slot (
            .en   (!rst),
            .head (head),
            .occ  (occ),
            .mem  (mem),
            .win  (win[k])
        );
    end

    assign bus.win0       = win[0];
    assign bus.win1       = win[1];
    assign bus.win2       = win[2];
    assign bus.win3       = win[3];
    assign bus.win4       = win[4];
    assign bus.win_count  = win_count;
    assign bus.issue_fire = fire;
    assign bus.len_err    = len_err_q;
    assign bus.occupancy  = occ;

    // Storage is not reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= (occ != '0) && bus.dec_ready && !legal;
            if (bus.flush) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                if (push)
                    tail <= tail + PTRW'(1);
                if (fire)
                    head <= head + PTRW'(bus.dec_len);
                occ <= occ + (PTRW+1)'(push)
                           - (fire ? (PTRW+1)'(bus.dec_len) : '0);
            end
        end
    end
endmodule

// File: tb/tb_inst_window.sv
// Scoreboard bench for inst_window: accepted longs are queued as expected
// window contents and popped as instructions issue.
module tb_inst_window;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_window_if #(.PTRW(3)) bus();

    inst_window #(.DEPTH(8), .PTRW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [63:0] exp_q[$];
    logic        m_err;

    logic        s_fire, s_rdy, s_err;
    logic [2:0]  s_cnt;
    logic [3:0]  s_occ;
    logic [63:0] s_win[5];
    logic        e_fire, e_rdy, e_err;
    logic [2:0]  e_cnt;
    logic [3:0]  e_occ;
    logic [63:0] e_win[5];

    // Drive one cycle, sample the DUT mid-cycle, compute the expected view
    // from the scoreboard, then advance the scoreboard across the edge.
    task automatic tick(input logic v, input logic [63:0] d, input logic fl,
                        input logic [2:0] len, input logic rdy);
        int sz;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = fl;
        bus.dec_len   = len;
        bus.dec_ready = rdy;
        #4;
        s_fire = bus.issue_fire; s_rdy = bus.in_ready; s_err = bus.len_err;
        s_cnt  = bus.win_count;  s_occ = bus.occupancy;
        s_win[0] = bus.win0; s_win[1] = bus.win1; s_win[2] = bus.win2;
        s_win[3] = bus.win3; s_win[4] = bus.win4;
        sz     = exp_q.size();
        e_occ  = 4'(sz);
        e_rdy  = !fl && (sz < 8);
        e_cnt  = (sz > 5) ? 3'd5 : 3'(sz);
        for (int k = 0; k < 5; k++) e_win[k] = (k < sz) ? exp_q[k] : 64'd0;
        e_fire = !fl && rdy && (len >= 3'd1) && (len <= 3'd5) && (len <= e_cnt);
        e_err  = m_err;
        m_err  = (sz > 0) && rdy && ((len == 3'd0) || (len > 3'd5));
        @(posedge clk); #1;
        if (fl) exp_q.delete();
        else begin
            if (e_fire) for (int i = 0; i < int'(len); i++) void'(exp_q.pop_front());
            if (v && e_rdy) exp_q.push_back(d);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0;
        bus.dec_len = 3'd0; bus.dec_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        m_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 64'hDEAD; bus.flush = 1'b0;
        bus.dec_len = 3'd1; bus.dec_ready = 1'b1;
        #4;
        n_run++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        n_run++; if (bus.issue_fire !== 1'b0) begin n_fail++; $display("FAIL rst_fire got %b want 0", bus.issue_fire); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.dec_ready = 1'b0;
        #4;
        n_run++; if (bus.occupancy !== 4'd0) begin n_fail++; $display("FAIL rst_occ got %0d want 0", bus.occupancy); end
        n_run++; if (bus.win_count !== 3'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", bus.win_count); end
        n_run++; if ({bus.win0, bus.win1, bus.win2, bus.win3, bus.win4} !== 320'd0) begin n_fail++; $display("FAIL rst_win got %h want 0", bus.win0); end
        n_run++; if (bus.len_err !== 1'b0) begin n_fail++; $display("FAIL rst_len_err got %b want 0", bus.len_err); end
        n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        exp_q.delete();
        m_err = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] a[5];
        logic rdy = 1'b1;
        int first = -1;
        do_reset();
        for (int i = 0; i < 5; i++) a[i] = 64'hA000_0000_0000_0000 | 64'(i);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, a[i], 1'b0, 3'd2, rdy);
            n_run++; if (s_fire !== e_fire) begin n_fail++; $display("FAIL basic_fire cyc %0d got %b want %b", i, s_fire, e_fire); end
            n_run++; if (s_win[0] !== e_win[0]) begin n_fail++; $display("FAIL basic_win0 cyc %0d got %h want %h", i, s_win[0], e_win[0]); end
            if (s_fire && first < 0) first = i;
            if (e_fire) rdy = 1'b0;
        end
        n_run++; if (first != 2) begin n_fail++; $display("FAIL basic_first_fire got %0d want 2", first); end
        tick(1'b0, 64'd0, 1'b0, 3'd2, 1'b0);
        n_run++; if (s_win[0] !== a[2]) begin n_fail++; $display("FAIL basic_after_win0 got %h want %h", s_win[0], a[2]); end
        n_run++; if (s_occ !== 4'd3) begin n_fail++; $display("FAIL basic_after_occ got %0d want 3", s_occ); end
    endtask

    task automatic test_stall();
        logic [63:0] b[3];
        do_reset();
        for (int i = 0; i < 3; i++) b[i] = 64'hB000_0000_0000_0000 | 64'(i);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, b[i], 1'b0, 3'd3, 1'b1);
            n_run++; if (s_fire !== 1'b0) begin n_fail++; $display("FAIL stall_fire cyc %0d got %b want 0", i, s_fire); end
            n_run++; if (s_cnt !== 3'(i)) begin n_fail++; $display("FAIL stall_cnt cyc %0d got %0d want %0d", i, s_cnt, i); end
        end
        tick(1'b0, 64'd0, 1'b0, 3'd3, 1'b1);
        n_run++; if (s_fire !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b want 1", s_fire); end
        for (int k = 0; k < 3; k++) begin
            n_run++; if (s_win[k] !== b[k]) begin n_fail++; $display("FAIL stall_win%0d got %h want %h", k, s_win[k], b[k]); end
        end
        tick(1'b0, 64'd0, 1'b0, 3'd3, 1'b0);
        n_run++; if (s_occ !== 4'd0) begin n_fail++; $display("FAIL stall_occ got %0d want 0", s_occ); end
    endtask

    task automatic test_full();
        logic [63:0] c[8];
        logic [63:0] y = 64'hC0FF_EE00_0000_0099;
        do_reset();
        for (int i = 0; i < 8; i++) c[i] = 64'hC000_0000_0000_0000 | 64'(i);
        for (int i = 0; i < 8; i++) tick(1'b1, c[i], 1'b0, 3'd5, 1'b0);
        tick(1'b1, 64'hBAD, 1'b0, 3'd5, 1'b1);
        n_run++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", s_rdy); end
        n_run++; if (s_fire !== 1'b1) begin n_fail++; $display("FAIL full_fire got %b want 1", s_fire); end
        n_run++; if (s_occ !== 4'd8) begin n_fail++; $display("FAIL full_occ got %0d want 8", s_occ); end
        tick(1'b0, 64'd0, 1'b0, 3'd5, 1'b0);
        n_run++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL full_after_ready got %b want 1", s_rdy); end
        n_run++; if (s_occ !== 4'd3) begin n_fail++; $display("FAIL full_after_occ got %0d want 3", s_occ); end
        n_run++; if (s_win[0] !== c[5]) begin n_fail++; $display("FAIL full_after_win0 got %h want %h", s_win[0], c[5]); end
        tick(1'b1, y, 1'b0, 3'd5, 1'b0);
        tick(1'b0, 64'd0, 1'b0, 3'd5, 1'b0);
        n_run++; if (s_occ !== 4'd4) begin n_fail++; $display("FAIL full_push_occ got %0d want 4", s_occ); end
        n_run++; if (s_win[3] !== y) begin n_fail++; $display("FAIL full_push_win3 got %h want %h", s_win[3], y); end
    endtask

    task automatic test_wrap();
        logic [63:0] e[5];
        do_reset();
        for (int i = 0; i < 5; i++) e[i] = 64'hE000_0000_0000_0000 | 64'(i);
        for (int i = 0; i < 6; i++) tick(1'b1, 64'hD0 + 64'(i), 1'b0, 3'd0, 1'b0);
        tick(1'b0, 64'd0, 1'b0, 3'd5, 1'b1);
        tick(1'b0, 64'd0, 1'b0, 3'd1, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, e[i], 1'b0, 3'd0, 1'b0);
        tick(1'b0, 64'd0, 1'b0, 3'd0, 1'b0);
        n_run++; if (s_cnt !== 3'd5) begin n_fail++; $display("FAIL wrap_cnt got %0d want 5", s_cnt); end
        for (int k = 0; k < 5; k++) begin
            n_run++; if (s_win[k] !== e[k]) begin n_fail++; $display("FAIL wrap_win%0d got %h want %h", k, s_win[k], e[k]); end
        end
        tick(1'b0, 64'd0, 1'b0, 3'd4, 1'b1);
        n_run++; if (s_fire !== 1'b1) begin n_fail++; $display("FAIL wrap_fire got %b want 1", s_fire); end
        tick(1'b0, 64'd0, 1'b0, 3'd4, 1'b0);
        n_run++; if (s_occ !== 4'd1) begin n_fail++; $display("FAIL wrap_occ got %0d want 1", s_occ); end
        n_run++; if (s_win[0] !== e[4]) begin n_fail++; $display("FAIL wrap_head got %h want %h", s_win[0], e[4]); end
    endtask

    task automatic test_flush();
        logic [63:0] h = 64'hF1F1_0000_0000_0001;
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 64'hF0 + 64'(i), 1'b0, 3'd0, 1'b0);
        tick(1'b1, 64'hBAD0_BAD0, 1'b1, 3'd2, 1'b1);
        n_run++; if (s_fire !== 1'b0) begin n_fail++; $display("FAIL flush_fire got %b want 0", s_fire); end
        n_run++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", s_rdy); end
        tick(1'b0, 64'd0, 1'b0, 3'd1, 1'b0);
        n_run++; if (s_occ !== 4'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", s_occ); end
        n_run++; if (s_cnt !== 3'd0) begin n_fail++; $display("FAIL flush_cnt got %0d want 0", s_cnt); end
        n_run++; if (s_win[0] !== 64'd0) begin n_fail++; $display("FAIL flush_win0 got %h want 0", s_win[0]); end
        tick(1'b1, h, 1'b0, 3'd1, 1'b0);
        tick(1'b0, 64'd0, 1'b0, 3'd1, 1'b0);
        n_run++; if (s_win[0] !== h || s_occ !== 4'd1) begin n_fail++; $display("FAIL flush_repush got %h/%0d want %h/1", s_win[0], s_occ, h); end
    endtask

    task automatic test_illegal();
        do_reset();
        tick(1'b0, 64'd0, 1'b0, 3'd7, 1'b1);
        tick(1'b1, 64'h11, 1'b0, 3'd0, 1'b0);
        n_run++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL illegal_empty got %b want 0", s_err); end
        tick(1'b1, 64'h22, 1'b0, 3'd0, 1'b0);
        tick(1'b0, 64'd0, 1'b0, 3'd0, 1'b1);
        n_run++; if (s_fire !== 1'b0) begin n_fail++; $display("FAIL illegal_fire0 got %b want 0", s_fire); end
        tick(1'b0, 64'd0, 1'b0, 3'd6, 1'b1);
        n_run++; if (s_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err0 got %b want 1", s_err); end
        n_run++; if (s_fire !== 1'b0) begin n_fail++; $display("FAIL illegal_fire6 got %b want 0", s_fire); end
        tick(1'b0, 64'd0, 1'b0, 3'd2, 1'b0);
        n_run++; if (s_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err6 got %b want 1", s_err); end
        n_run++; if (s_occ !== 4'd2) begin n_fail++; $display("FAIL illegal_occ got %0d want 2", s_occ); end
        tick(1'b0, 64'd0, 1'b0, 3'd2, 1'b0);
        n_run++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse got %b want 0", s_err); end
    endtask

    task automatic test_back_to_back();
        logic       v, fl, rdy;
        logic [2:0] len;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 40) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            len = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
            tick(v, {$urandom, $urandom}, fl, len, rdy);
            n_run++; if (s_fire !== e_fire) begin n_fail++; $display("FAIL b2b_fire cyc %0d got %b want %b", i, s_fire, e_fire); end
            n_run++; if (s_rdy !== e_rdy) begin n_fail++; $display("FAIL b2b_ready cyc %0d got %b want %b", i, s_rdy, e_rdy); end
            n_run++; if (s_occ !== e_occ) begin n_fail++; $display("FAIL b2b_occ cyc %0d got %0d want %0d", i, s_occ, e_occ); end
            n_run++; if (s_cnt !== e_cnt) begin n_fail++; $display("FAIL b2b_cnt cyc %0d got %0d want %0d", i, s_cnt, e_cnt); end
            n_run++; if (s_err !== e_err) begin n_fail++; $display("FAIL b2b_len_err cyc %0d got %b want %b", i, s_err, e_err); end
            for (int k = 0; k < 5; k++) begin
                n_run++; if (s_win[k] !== e_win[k]) begin n_fail++; $display("FAIL b2b_win%0d cyc %0d got %h want %h", k, i, s_win[k], e_win[k]); end
            end
        end
        // Reset in the middle of traffic drops everything in the same edge.
        for (int i = 0; i < 4; i++) tick(1'b1, 64'h77 + 64'(i), 1'b0, 3'd0, 1'b0);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.dec_len = 3'd1; bus.dec_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.dec_ready = 1'b0;
        #4;
        n_run++; if (bus.occupancy !== 4'd0 || bus.win_count !== 3'd0) begin n_fail++; $display("FAIL midrst got %0d/%0d want 0/0", bus.occupancy, bus.win_count); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0;
        bus.dec_len = 3'd0; bus.dec_ready = 1'b0;
        m_err = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_stall();
        test_full();
        test_wrap();
        test_flush();
        test_illegal();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_window.md
Name: inst_window

Overview:
- Instruction-stream window controller for the dispatch stage.
- Buffers 64-bit longs from fetch in a circular queue and presents the oldest five as the decoder's window (win0..win4).
- Takes the decoder's combinational instruction length (1..5 longs) and retires exactly that many longs when the instruction issues.
- Provides flush for taken branches / jumps.

Parameters:
- DEPTH, 8, queue capacity in longs; power of two, minimum 8.
- PTRW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  fetch long valid
- in_data  input  64  fetch long
- in_ready  output  1  queue can accept a long this cycle
- flush  input  1  discard all buffered longs
- win0..win4  output  64 each  window slots; win0 is the oldest long
- win_count  output  3  number of valid window slots (0..5)
- dec_len  input  3  decoder length for the instruction at win0
- dec_ready  input  1  downstream can accept the instruction this cycle
- issue_fire  output  1  instruction issued; dec_len longs retired
- len_err  output  1  one-cycle pulse on an illegal dec_len
- occupancy  output  PTRW+1  longs currently buffered

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - head = 0, tail = 0, occupancy = 0.
  - issue_fire = 0, len_err = 0.
  - in_ready = 0 while rst is high.
  - win0..win4 = 0, win_count = 0.
- Storage: DEPTH x 64 register array. head is the read pointer, tail the write pointer. Both are PTRW bits and wrap modulo DEPTH.
- in_ready = !rst && !flush && (occupancy < DEPTH), computed from the registered occupancy. There is no same-cycle bypass from a retire.
- Push: when in_valid && in_ready, mem[tail] <= in_data and tail increments.
- Window (combinational):
  - win_k = mem[head+k mod DEPTH] if k < occupancy, else 0.
  - win_count = min(occupancy, 5).
- Length legality: dec_len in 1..5 is legal; 0, 6 and 7 are illegal.
- issue_fire (combinational) = !rst && !flush && dec_ready && legal(dec_len) && (dec_len <= win_count).
- Retire: on issue_fire, head <= head + dec_len (mod DEPTH).
- Occupancy update: occupancy <= occupancy + push - (issue_fire ? dec_len : 0). Simultaneous push and retire are both applied in the same cycle.
- len_err: registered; set for one cycle when occupancy > 0, dec_ready = 1 and dec_len is illegal. No retire happens in that cycle. The queue state is otherwise unchanged.
- Flush: highest priority.
  - head <= 0, tail <= 0, occupancy <= 0.
  - Any push or retire presented in the same cycle is discarded.
  - The window reads zero from the next cycle.
- Partial instruction: when dec_len > win_count there is no retire. The block waits for fetch to deliver more longs (stall); there is no timeout.
- Empty queue: win_count = 0 and issue_fire = 0 regardless of dec_len.
- Full queue: in_ready = 0. A retire in that cycle frees slots starting the next cycle.
- Wrap-around: the window and retire indices wrap modulo DEPTH. Window slots that straddle the wrap boundary present data in order.
- Reset mid-operation: the synchronous reset clears the queue in the same edge. Any in-flight push or retire in that cycle is lost.
- Combinational loop: dec_len depends only on the window contents. issue_fire must not feed back into win0..win4 within the cycle.

Test Plan:
- Basic: after reset, push A0..A4 (5 longs) with dec_len = 2 and dec_ready = 1 held. Required: issue_fire first when win_count >= 2; afterwards win0 = A2, occupancy = 3.
- Stall: push 1 long with dec_len = 3. Required: issue_fire = 0 and win_count = 1. Push 2 more longs -> issue_fire = 1 on the cycle win_count reaches 3, occupancy returns to 0.
- Full and simultaneous: fill 8 longs -> in_ready = 0. Next cycle present in_valid with dec_len = 5 and dec_ready = 1. Required: retire 5, no push that cycle; the following cycle in_ready = 1 and occupancy = 3; a push then gives 4.
- Wrap: with head = 6, push so that slots 6, 7, 0, 1, 2 are valid. Required: win0..win4 = mem[6], mem[7], mem[0], mem[1], mem[2]; dec_len = 4 -> head = 2.
- Flush priority: occupancy = 5 with flush, in_valid and issue_fire conditions all present in one cycle. Required: occupancy = 0, head = tail = 0 next cycle, no long written, win_count = 0.
- Illegal length: occupancy = 2, dec_len = 0 and then 6, dec_ready = 1. Required: len_err pulses each cycle, issue_fire = 0, occupancy stays 2.
